mem_dbus_ctrl: RTL

- MEM-stage data-bus controller in the dual-issue MIPS pipeline. It sits directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory op, address and store data, and issues one SRAM-like data-bus transaction per op.
- Holds the pipeline through stallreq_o until the transaction finishes, then returns the aligned and extended load result to the MEM/WB path.
- Detects misaligned addresses itself (AdEL/AdES) and never issues a bus request for them.

---
 rtl/mem_dbus_ctrl.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_dbus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_dbus_ctrl
// MEM-stage data-bus controller for the dual-issue MIPS pipeline. Takes the
// registered memory op from EX/MEM, runs exactly one SRAM-like data-bus
// transaction for it, stalls the pipeline until that transaction finishes and
// returns the aligned, sign/zero-extended load result. Misaligned accesses
// are reported as AdEL/AdES and never reach the bus.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               exception flush, kills the op in flight
//   mem_op_i            0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW
//   mem_addr_i          effective address
//   store_data_i        rt value for stores
//   excp_pending_i      older exception on this slot, suppresses the access
//   data_req_o .. data_wstrb_o     bus request channel
//   data_addr_ok_i, data_data_ok_i, data_rdata_i   bus handshake / read data
//   stallreq_o          stall request to the pipeline controller
//   load_data_o, load_valid_o      extended load result, valid for one cycle
//   adel_o, ades_o      load / store address error (combinational)
// ---------------------------------------------------------------------------
module mem_dbus_ctrl #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [3:0]        mem_op_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic              excp_pending_i,
    output logic              data_req_o,
    output logic              data_wr_o,
    output logic [1:0]        data_size_o,
    output logic [ADDR_W-1:0] data_addr_o,
    output logic [DATA_W-1:0] data_wdata_o,
    output logic [3:0]        data_wstrb_o,
    input  logic              data_addr_ok_i,
    input  logic              data_data_ok_i,
    input  logic [DATA_W-1:0] data_rdata_i,
    output logic              stallreq_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              load_valid_o,
    output logic              adel_o,
    output logic              ades_o
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } stateType;

    stateType r_state;
    stateType w_next;

    logic [3:0]        r_op;
    logic [1:0]        r_addrLow;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [3:0]        r_wstrb;
    logic [DATA_W-1:0] r_loadData;

    logic w_isLoadOp, w_isStoreOp, w_isHalf, w_isWord;
    logic w_opValid, w_misaligned, w_issue;
    logic w_latch, w_capture, w_latchedLoad;
    logic [1:0]        w_reqSize;
    logic [3:0]        w_reqStrb;
    logic [DATA_W-1:0] w_reqWdata;
    logic [7:0]        w_byteSel;
    logic [15:0]       w_halfSel;
    logic [DATA_W-1:0] w_extended;

    // Op decode; codes 9-15 fall through as "no op".
    always_comb begin
        w_isLoadOp  = 1'b0;
        w_isStoreOp = 1'b0;
        w_isHalf    = 1'b0;
        w_isWord    = 1'b0;
        case (mem_op_i)
            OP_LB, OP_LBU: w_isLoadOp = 1'b1;
            OP_LH, OP_LHU: begin w_isLoadOp = 1'b1; w_isHalf = 1'b1; end
            OP_LW:         begin w_isLoadOp = 1'b1; w_isWord = 1'b1; end
            OP_SB:         w_isStoreOp = 1'b1;
            OP_SH:         begin w_isStoreOp = 1'b1; w_isHalf = 1'b1; end
            OP_SW:         begin w_isStoreOp = 1'b1; w_isWord = 1'b1; end
            default:       ;
        endcase
    end

    assign w_opValid    = w_isLoadOp | w_isStoreOp;
    assign w_misaligned = (w_isHalf & mem_addr_i[0]) | (w_isWord & (mem_addr_i[1:0] != 2'b00));
    assign adel_o       = w_opValid & w_misaligned & w_isLoadOp;
    assign ades_o       = w_opValid & w_misaligned & w_isStoreOp;
    assign w_issue      = w_opValid & ~w_misaligned & ~excp_pending_i & ~flush;

    // Request fields captured at issue: size code, byte strobes and
    // lane-replicated store data so the slave can pick any lane.
    always_comb begin
        w_reqSize  = w_isWord ? 2'd2 : (w_isHalf ? 2'd1 : 2'd0);
        w_reqStrb  = 4'b0000;
        w_reqWdata = '0;
        if (w_isStoreOp) begin
            if (w_isWord) begin
                w_reqStrb  = 4'b1111;
                w_reqWdata = store_data_i;
            end else if (w_isHalf) begin
                w_reqStrb  = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                w_reqWdata = {2{store_data_i[15:0]}};
            end else begin
                w_reqStrb  = 4'b0001 << mem_addr_i[1:0];
                w_reqWdata = {4{store_data_i[7:0]}};
            end
        end
    end

    // Pick the addressed byte/half from the read word and extend it
    // according to the latched op.
    always_comb begin
        case (r_addrLow)
            2'd0:    w_byteSel = data_rdata_i[7:0];
            2'd1:    w_byteSel = data_rdata_i[15:8];
            2'd2:    w_byteSel = data_rdata_i[23:16];
            default: w_byteSel = data_rdata_i[31:24];
        endcase
        w_halfSel = r_addrLow[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        case (r_op)
            OP_LB:   w_extended = {{24{w_byteSel[7]}}, w_byteSel};
            OP_LBU:  w_extended = {24'h0, w_byteSel};
            OP_LH:   w_extended = {{16{w_halfSel[15]}}, w_halfSel};
            OP_LHU:  w_extended = {16'h0, w_halfSel};
            OP_LW:   w_extended = data_rdata_i;
            default: w_extended = '0;
        endcase
    end

    assign w_latchedLoad = (r_op >= OP_LB) && (r_op <= OP_LW);

    // Next-state and handshake outputs. A flush after the slave accepted the
    // request must still swallow the response (DRAIN), unless that response
    // arrives in the same cycle, in which case there is nothing left to wait for.
    always_comb begin
        w_next       = r_state;
        stallreq_o   = 1'b0;
        data_req_o   = 1'b0;
        load_valid_o = 1'b0;
        w_latch      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next     = S_REQ;
                    stallreq_o = 1'b1;
                    w_latch    = 1'b1;
                end
            end
            S_REQ: begin
                data_req_o = 1'b1;
                stallreq_o = 1'b1;
                if (flush) begin
                    if (data_addr_ok_i && !data_data_ok_i) begin
                        w_next = S_DRAIN;
                    end else begin
                        w_next = S_IDLE;
                    end
                end else if (data_addr_ok_i) begin
                    if (data_data_ok_i) begin
                        w_next    = S_DONE;
                        w_capture = w_latchedLoad;
                    end else begin
                        w_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stallreq_o = 1'b1;
                if (flush) begin
                    w_next = data_data_ok_i ? S_IDLE : S_DRAIN;
                end else if (data_data_ok_i) begin
                    w_next    = S_DONE;
                    w_capture = w_latchedLoad;
                end
            end
            S_DONE: begin
                load_valid_o = w_latchedLoad & ~flush;
                w_next       = S_IDLE;
            end
            S_DRAIN: begin
                stallreq_o = w_opValid;
                if (data_data_ok_i) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State and latched transaction registers; reset drops any outstanding
    // transaction without waiting for its response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= 4'd0;
            r_addrLow  <= 2'd0;
            r_wr       <= 1'b0;
            r_size     <= 2'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wstrb    <= 4'b0000;
            r_loadData <= '0;
        end else begin
            r_state <= w_next;
            if (w_latch) begin
                r_op      <= mem_op_i;
                r_addrLow <= mem_addr_i[1:0];
                r_wr      <= w_isStoreOp;
                r_size    <= w_reqSize;
                r_addr    <= mem_addr_i;
                r_wdata   <= w_reqWdata;
                r_wstrb   <= w_reqStrb;
            end
            if (w_capture) begin
                r_loadData <= w_extended;
            end
        end
    end

    assign data_wr_o    = r_wr;
    assign data_size_o  = r_size;
    assign data_addr_o  = r_addr;
    assign data_wdata_o = r_wdata;
    assign data_wstrb_o = r_wstrb;
    assign load_data_o  = r_loadData;

endmodule
